// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round sequencer: owns the state register, round counter and key fetch.
// Optional round-key cache enabled by defining AES_CTRL_KEY_CACHE_EN.
module aes_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         rk_req,
  output logic [3:0]   rk_idx,
  input  logic         rk_valid,
  input  logic [127:0] rk_data,
  output logic [127:0] dp_state,
  output logic [127:0] dp_key,
  output logic         dp_final,
  input  logic [127:0] dp_result,
  input  logic         key_flush,
  output logic         busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] LAST_RND = 4'(NR);

  logic [1:0]   fsm;
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [3:0]   rnd;
  logic         rk_req_q;
  logic [3:0]   rk_idx_q;

  logic         fetch_ok;
  logic [127:0] fetch_key;
  logic         req_needed;

`ifdef AES_CTRL_KEY_CACHE_EN
  logic [127:0] cache_mem [0:NR];
  logic [NR:0]  cache_vld;
  logic [3:0]   req_idx;

  // Index of the key the next FETCH will need, decided one cycle early so rk_req stays registered.
  always_comb begin
    req_idx = 4'd0;
    case (fsm)
      S_FETCH: req_idx = 4'd1;
      S_EXEC:  req_idx = rnd + 4'd1;
      default: req_idx = 4'd0;
    endcase
  end

  assign req_needed = !(cache_vld[req_idx] && !key_flush);
  assign fetch_ok   = rk_req_q ? rk_valid : 1'b1;
  assign fetch_key  = rk_req_q ? rk_data : cache_mem[rnd];

  always_ff @(posedge clk) begin
    if (rst || key_flush) begin
      cache_vld <= '0;
    end else if (fsm == S_FETCH && rk_req_q && rk_valid) begin
      cache_vld[rnd] <= 1'b1;
    end
  end

  // NOTE: key storage has no reset; the valid bits alone decide whether an entry is used.
  always_ff @(posedge clk) begin
    if (fsm == S_FETCH && rk_req_q && rk_valid) begin
      cache_mem[rnd] <= rk_data;
    end
  end
`else
  logic unused_key_flush;

  assign unused_key_flush = key_flush;
  assign req_needed       = 1'b1;
  assign fetch_ok         = rk_valid;
  assign fetch_key        = rk_data;
`endif

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= S_IDLE;
      state_q  <= '0;
      key_q    <= '0;
      rnd      <= '0;
      rk_req_q <= 1'b0;
      rk_idx_q <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (in_valid) begin
            state_q  <= in_block;
            rnd      <= 4'd0;
            rk_idx_q <= 4'd0;
            rk_req_q <= req_needed;
            fsm      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fetch_ok) begin
            if (rnd == 4'd0) begin
              // Initial whitening with round key 0, then fetch key 1 without executing.
              state_q  <= state_q ^ fetch_key;
              rnd      <= 4'd1;
              rk_idx_q <= 4'd1;
              rk_req_q <= req_needed;
            end else begin
              key_q    <= fetch_key;
              rk_req_q <= 1'b0;
              fsm      <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          state_q <= dp_result;
          if (rnd == LAST_RND) begin
            fsm <= S_DONE;
          end else begin
            rnd      <= rnd + 4'd1;
            rk_idx_q <= rnd + 4'd1;
            rk_req_q <= req_needed;
            fsm      <= S_FETCH;
          end
        end
        default: begin
          if (out_ready) begin
            fsm <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready  = (fsm == S_IDLE);
  assign out_valid = (fsm == S_DONE);
  assign out_block = state_q;
  assign rk_req    = rk_req_q;
  assign rk_idx    = rk_idx_q;
  assign dp_state  = state_q;
  assign dp_key    = key_q;
  assign dp_final  = (fsm == S_EXEC) && (rnd == LAST_RND);
  assign busy      = (fsm == S_FETCH) || (fsm == S_EXEC);

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative round sequencer for the AES encryption core. It accepts one 128-bit plaintext block over a valid/ready handshake and fetches round keys from the key schedule. Each round it drives the shared single-round datapath (SubBytes → ShiftRows → MixColumns → AddRoundKey), feeds the result back, and presents the ciphertext on an output handshake. It sits between the block I/O wrapper and the combinational round datapath, and owns the state register and round counter.

## Interface

- `NR`, default 10: number of rounds; legal values 10, 12, 14 (AES-128/192/256).

Reset is synchronous and active-high.

- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous reset.
- `in_valid` in 1: plaintext offered.
- `in_ready` out 1: controller idle, accepting.
- `in_block` in 128: plaintext, byte 0 in [7:0].
- `out_valid` out 1: ciphertext available.
- `out_ready` in 1: consumer accepts ciphertext.
- `out_block` out 128: ciphertext.
- `rk_req` out 1: round-key request, held until `rk_valid`.
- `rk_idx` out 4: requested round-key index 0..NR.
- `rk_valid` in 1: `rk_data` valid for `rk_idx`; ignored while `rk_req`=0.
- `rk_data` in 128: round key.
- `dp_state` out 128: state into round datapath.
- `dp_key` out 128: round key into datapath.
- `dp_final` out 1: final round, datapath bypasses MixColumns.
- `dp_result` in 128: combinational round result.
- `key_flush` in 1: invalidate cached round keys (see Configuration).
- `busy` out 1: high in any state but IDLE/DONE.

## Operation

- FSM states: IDLE, FETCH, EXEC, DONE.
- IDLE: `in_ready`=1. On `in_valid`: `state`←`in_block`, `rnd`←0, go to FETCH.
- FETCH: `rk_req`=1, `rk_idx`=`rnd`. Wait for `rk_valid`, any number of cycles.
  - `rnd`=0: `state`←`state`^`rk_data` (initial whitening); `rnd`←1; stay in FETCH.
  - `rnd`>0: `key`←`rk_data`; go to EXEC.
- EXEC: `dp_state`=`state`, `dp_key`=`key`, `dp_final`=(`rnd`==NR); `state`←`dp_result`.
  - `rnd`==NR: go to DONE.
  - Otherwise `rnd`←`rnd`+1; go to FETCH.
- DONE: `out_valid`=1, `out_block`=`state`. When `out_ready`=1, go to IDLE. No new input is accepted in DONE.
- `dp_state`/`dp_key` are driven from registers in every state. `dp_final` is 0 outside EXEC.
- `rnd` is 4 bits; it never exceeds NR; no wrap.
- `in_valid` outside IDLE is ignored; `in_ready` is 0.
- Reset (any state, including mid-block): FSM→IDLE. `state`, `key`, `rnd` and all outputs →0, except `in_ready`=1 once in IDLE. The cache is invalidated. The in-flight block is discarded; no `out_valid` is produced for it.

## Timing

- Acceptance handshake at cycle T0. With `rk_valid` returned in the same cycle as `rk_req`, `out_valid` rises at T0+2·NR+2 (cycle 22 for NR=10).
- Each cycle of `rk_valid` delay adds exactly one cycle.
- `out_block` is stable while `out_valid`=1 and `out_ready`=0.
- The earliest next acceptance is the cycle after the output handshake.
- `rk_req`/`rk_idx` are registered. `rk_idx` is stable while `rk_req`=1.

## Configuration

- Macro: `AES_CTRL_KEY_CACHE_EN`.
- **Defined:**
  - Adds a local (NR+1)×128 round-key store with a per-index valid bit.
  - In FETCH, a valid entry is used directly: FETCH still takes one cycle and `rk_req` stays 0. A miss behaves as uncached and writes the entry.
  - `key_flush`=1 clears all valid bits. If it arrives during a block, it takes effect for subsequent fetches.
- **Undefined:** no store; every FETCH requests; `key_flush` is ignored.

## Test plan

- **FIPS-197 vector (NR=10):** plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, zero-wait key model → `out_block`=69c4e0d86a7b0430d8cdb78070b4c55a, `out_valid` at T0+22, exactly 11 `rk_req` handshakes with `rk_idx` 0..10.
- **Key-schedule stall:** `rk_valid` delayed 3 cycles on every request → same ciphertext, `out_valid` at T0+22+33. `rk_idx` holds steady during each stall.
- **Output backpressure:** `out_ready`=0 for 5 cycles after DONE → `out_block` unchanged, `in_ready`=0, second `in_valid` not accepted until the cycle after the output handshake.
- **Reset mid-block:** `rst` asserted when `rnd`=5 → next cycle all outputs 0, `in_ready`=1. A new block then completes correctly with no spurious `out_valid`.
- **Final-round flag:** monitor `dp_final` → high only in the single EXEC cycle with `rnd`=NR. Repeat with NR=14 for an AES-256 vector (key 000102…1f → 8ea2b7ca516745bfeafc49904b496089).
- **Key cache (macro defined):** two back-to-back blocks with the same key → 11 requests on the first block, 0 on the second. Pulse `key_flush` → next block issues 11 requests again.
